// File: rtl/rc4_encryptor.sv
// rtl/rc4_encryptor.sv - RC4 stream cipher engine driving external S-box RAM, plaintext ROM and ciphertext RAM
module rc4_encryptor #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_wren,
  input  logic [7:0]  s_rdata,
  output logic [7:0]  p_addr,
  input  logic [7:0]  p_rdata,
  output logic [7:0]  c_addr,
  output logic [7:0]  c_wdata,
  output logic        c_wren,
  output logic        busy,
  output logic        done
);

  // Every memory read takes one cycle: each *_RD_* state drives the address,
  // the matching *_WAIT_* state holds it and captures the returned byte.
  localparam logic [4:0] S_IDLE        = 5'd0;
  localparam logic [4:0] S_INIT        = 5'd1;
  localparam logic [4:0] S_KSA_RD_I    = 5'd2;
  localparam logic [4:0] S_KSA_WAIT_I  = 5'd3;
  localparam logic [4:0] S_KSA_RD_J    = 5'd4;
  localparam logic [4:0] S_KSA_WAIT_J  = 5'd5;
  localparam logic [4:0] S_KSA_WR_I    = 5'd6;
  localparam logic [4:0] S_KSA_WR_J    = 5'd7;
  localparam logic [4:0] S_PRGA_RD_I   = 5'd8;
  localparam logic [4:0] S_PRGA_WAIT_I = 5'd9;
  localparam logic [4:0] S_PRGA_RD_J   = 5'd10;
  localparam logic [4:0] S_PRGA_WAIT_J = 5'd11;
  localparam logic [4:0] S_PRGA_WR_I   = 5'd12;
  localparam logic [4:0] S_PRGA_WR_J   = 5'd13;
  localparam logic [4:0] S_PRGA_RD_F   = 5'd14;
  localparam logic [4:0] S_PRGA_WAIT_F = 5'd15;
  localparam logic [4:0] S_PRGA_WR_C   = 5'd16;
  localparam logic [4:0] S_DONE        = 5'd17;

  // Index of the final message byte; the counter is 9 bits so MSG_LEN=256 still ends.
  localparam logic [8:0] LAST_K = 9'(MSG_LEN - 1);

  logic [4:0]  state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [8:0]  k_q, k_d;
  logic [23:0] key_q, key_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [7:0]  c_q, c_d;

  logic [7:0]  key_byte;
  logic [7:0]  f_addr;

  // Key byte used by the current KSA step: key[i mod 3], byte 0 in the top bits.
  always_comb begin
    key_byte = 8'h00;
    case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      2'd2:    key_byte = key_q[7:0];
      default: key_byte = 8'h00;
    endcase
  end

  // Post-swap s[i]+s[j] equals old s[j]+old s[i], so the saved bytes give the f address.
  assign f_addr = si_q + sj_q;

  // Next-state and datapath updates for the whole INIT / KSA / PRGA sequence.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    key_d   = key_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    c_d     = c_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          key_d   = secret_key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 9'd0;
          kidx_d  = 2'd0;
        end
      end

      S_INIT: begin
        // i wraps back to 0 after the last identity write, ready for KSA.
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = S_KSA_RD_I;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
        end
      end

      S_KSA_RD_I: state_d = S_KSA_WAIT_I;

      S_KSA_WAIT_I: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata + key_byte;
        state_d = S_KSA_RD_J;
      end

      S_KSA_RD_J: state_d = S_KSA_WAIT_J;

      S_KSA_WAIT_J: begin
        sj_d    = s_rdata;
        state_d = S_KSA_WR_I;
      end

      S_KSA_WR_I: state_d = S_KSA_WR_J;

      S_KSA_WR_J: begin
        i_d    = i_q + 8'd1;
        kidx_d = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
        if (i_q == 8'hFF) begin
          // PRGA pre-increments i, so the first byte reads s[1].
          state_d = S_PRGA_RD_I;
          i_d     = 8'd1;
          j_d     = 8'd0;
          k_d     = 9'd0;
        end else begin
          state_d = S_KSA_RD_I;
        end
      end

      S_PRGA_RD_I: state_d = S_PRGA_WAIT_I;

      S_PRGA_WAIT_I: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = S_PRGA_RD_J;
      end

      S_PRGA_RD_J: state_d = S_PRGA_WAIT_J;

      S_PRGA_WAIT_J: begin
        sj_d    = s_rdata;
        state_d = S_PRGA_WR_I;
      end

      S_PRGA_WR_I: state_d = S_PRGA_WR_J;

      S_PRGA_WR_J: state_d = S_PRGA_RD_F;

      S_PRGA_RD_F: state_d = S_PRGA_WAIT_F;

      S_PRGA_WAIT_F: begin
        // Keystream byte and plaintext byte arrive together.
        c_d     = s_rdata ^ p_rdata;
        state_d = S_PRGA_WR_C;
      end

      S_PRGA_WR_C: begin
        if (k_q == LAST_K) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 9'd1;
          i_d     = i_q + 8'd1;
          state_d = S_PRGA_RD_I;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 9'd0;
      key_q   <= 24'd0;
      kidx_q  <= 2'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      c_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      c_q     <= c_d;
    end
  end

  // Memory-port decode: addresses, write data and strobes are zero outside active states.
  always_comb begin
    s_addr  = 8'd0;
    s_wdata = 8'd0;
    s_wren  = 1'b0;
    p_addr  = 8'd0;
    c_addr  = 8'd0;
    c_wdata = 8'd0;
    c_wren  = 1'b0;

    case (state_q)
      S_INIT: begin
        s_addr  = i_q;
        s_wdata = i_q;
        s_wren  = 1'b1;
      end

      S_KSA_RD_I, S_KSA_WAIT_I, S_PRGA_RD_I, S_PRGA_WAIT_I: begin
        s_addr = i_q;
      end

      S_KSA_RD_J, S_KSA_WAIT_J, S_PRGA_RD_J, S_PRGA_WAIT_J: begin
        s_addr = j_q;
      end

      S_KSA_WR_I, S_PRGA_WR_I: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
      end

      S_KSA_WR_J, S_PRGA_WR_J: begin
        // When i==j this rewrites the same byte with its original value.
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
      end

      S_PRGA_RD_F, S_PRGA_WAIT_F: begin
        s_addr = f_addr;
        p_addr = k_q[7:0];
      end

      S_PRGA_WR_C: begin
        c_addr  = k_q[7:0];
        c_wdata = c_q;
        c_wren  = 1'b1;
      end

      default: begin
        s_addr = 8'd0;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_rc4_encryptor.sv
// tb/tb_rc4_encryptor.sv - scoreboard bench for rc4_encryptor at MSG_LEN 9, 32 and 256
module tb_rc4_encryptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [23:0]      secret_key;
  logic [2:0]       start_v;
  logic [2:0][7:0]  s_addr_v, s_wdata_v, p_addr_v, c_addr_v, c_wdata_v;
  logic [2:0]       s_wren_v, c_wren_v, busy_v, done_v;
  logic [7:0]       s_rdata, p_rdata;
  logic [1:0]       sel;

  logic [7:0]  smem [256];
  logic [7:0]  pmem [256];
  logic [7:0]  cmem [256];
  logic [7:0]  ks [256];
  logic [15:0] exp_q [$];

  int compared = 0;
  int failed = 0;

  logic [71:0] pt_text = "Plaintext";
  logic [71:0] ct_ref  = 72'hBBF316E8D940AF0AD3;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rc4_encryptor #(.MSG_LEN(g == 0 ? 9 : (g == 1 ? 32 : 256))) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start_v[g]),
      .secret_key (secret_key),
      .s_addr     (s_addr_v[g]),
      .s_wdata    (s_wdata_v[g]),
      .s_wren     (s_wren_v[g]),
      .s_rdata    (s_rdata),
      .p_addr     (p_addr_v[g]),
      .p_rdata    (p_rdata),
      .c_addr     (c_addr_v[g]),
      .c_wdata    (c_wdata_v[g]),
      .c_wren     (c_wren_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g])
    );
  end

  // Shared one-cycle-latency memories, attached to the instance selected by sel.
  always @(posedge clk) begin
    if (s_wren_v[sel]) smem[s_addr_v[sel]] <= s_wdata_v[sel];
    s_rdata <= smem[s_addr_v[sel]];
    p_rdata <= pmem[p_addr_v[sel]];
    if (c_wren_v[sel]) cmem[c_addr_v[sel]] <= c_wdata_v[sel];
  end

  task automatic compute_ks(input logic [23:0] kk, input int n);
    int s [256];
    int kb [3];
    int i, j, t;
    kb[0] = int'(kk[23:16]);
    kb[1] = int'(kk[15:8]);
    kb[2] = int'(kk[7:0]);
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + kb[x % 3]) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int x = 0; x < n; x++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[x] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic push_model(input int n);
    for (int x = 0; x < n; x++) exp_q.push_back({8'(x), ks[x] ^ pmem[x]});
  endtask

  task automatic push_ref_vector();
    for (int x = 0; x < 9; x++) exp_q.push_back({8'(x), ct_ref[71 - 8 * x -: 8]});
  endtask

  task automatic load_plaintext();
    for (int x = 0; x < 256; x++) pmem[x] = 8'h00;
    for (int x = 0; x < 9; x++) pmem[x] = pt_text[71 - 8 * x -: 8];
  endtask

  task automatic pulse_start(input int g, input logic [23:0] kk);
    secret_key = kk;
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  // Runs the selected instance to done, popping the scoreboard on every c_wren.
  // With poke_done set, start is held high across the DONE and following IDLE cycles.
  task automatic drain_run(input int budget, input bit poke_done,
                           output int cw, output int dn, output logic [1:0] busy_obs);
    int cyc = 0;
    int tail = 0;
    bit seen = 0;
    bit idle_bad = 0;
    logic [15:0] e;
    cw = 0;
    dn = 0;
    busy_obs = 2'b11;
    while (tail < 4 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!busy_v[sel] && (s_wren_v[sel] || c_wren_v[sel])) idle_bad = 1;
      if (c_wren_v[sel]) begin
        cw++;
        compared++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL c_write_extra: addr=%02h data=%02h, required no write", c_addr_v[sel], c_wdata_v[sel]);
        end else begin
          e = exp_q.pop_front();
          if ({c_addr_v[sel], c_wdata_v[sel]} !== e) begin
            failed++;
            $display("FAIL c_write: addr/data=%02h/%02h, required %02h/%02h", c_addr_v[sel], c_wdata_v[sel], e[15:8], e[7:0]);
          end
        end
      end
      if (seen) tail++;
      if (seen && poke_done && tail == 1) busy_obs[0] = busy_v[sel];
      if (seen && poke_done && tail == 2) begin
        busy_obs[1] = busy_v[sel];
        start_v[sel] = 1'b0;
      end
      if (done_v[sel] && !seen) begin
        dn++;
        seen = 1;
        if (poke_done) start_v[sel] = 1'b1;
      end else if (done_v[sel]) begin
        dn++;
      end
    end
    compared++;
    if (!seen) begin
      failed++;
      $display("FAIL run_timeout: no done within %0d cycles, required done", budget);
    end
    compared++;
    if (idle_bad) begin
      failed++;
      $display("FAIL wren_when_idle: write strobe seen with busy low, required none");
    end
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL c_write_missing: %0d writes outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_v = 3'b000;
    secret_key = 24'h0;
    sel = 2'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      compared++;
      if ({busy_v[g], done_v[g], s_wren_v[g], c_wren_v[g], s_addr_v[g], s_wdata_v[g],
           p_addr_v[g], c_addr_v[g], c_wdata_v[g]} !== 44'h0) begin
        failed++;
        $display("FAIL reset_state[%0d]: busy=%b done=%b s_wren=%b c_wren=%b s_addr=%02h, required all zero",
                 g, busy_v[g], done_v[g], s_wren_v[g], c_wren_v[g], s_addr_v[g]);
      end
    end
  endtask

  task automatic test_init();
    logic [23:0] kk;
    int n = 0;
    int bad = 0;
    int addr_bad = 0;
    int cw, dn;
    logic [1:0] bo;
    sel = 2'd0;
    kk = 24'($urandom);
    for (int x = 0; x < 256; x++) pmem[x] = 8'($urandom);
    compute_ks(kk, 9);
    push_model(9);
    pulse_start(0, kk);
    compared++;
    if (busy_v[0] !== 1'b1) begin
      failed++;
      $display("FAIL busy_after_start: busy=%b, required 1", busy_v[0]);
    end
    while (s_wren_v[0] === 1'b1 && n < 300) begin
      if (s_addr_v[0] !== 8'(n) || s_wdata_v[0] !== 8'(n)) addr_bad++;
      n++;
      @(negedge clk);
    end
    compared++;
    if (n != 256 || addr_bad != 0) begin
      failed++;
      $display("FAIL init_writes: count=%0d bad_addr=%0d, required 256 and 0", n, addr_bad);
    end
    for (int x = 0; x < 256; x++) if (smem[x] !== 8'(x)) bad++;
    compared++;
    if (bad != 0) begin
      failed++;
      $display("FAIL init_identity: %0d entries differ, required 0", bad);
    end
    drain_run(6000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 9 || dn != 1) begin
      failed++;
      $display("FAIL init_run_counts: c_wren=%0d done=%0d, required 9 and 1", cw, dn);
    end
  endtask

  task automatic test_known_vector();
    int cw, dn;
    logic [1:0] bo;
    sel = 2'd0;
    load_plaintext();
    push_ref_vector();
    pulse_start(0, 24'h4B6579);
    drain_run(6000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 9 || dn != 1) begin
      failed++;
      $display("FAIL known_counts: c_wren=%0d done=%0d, required 9 and 1", cw, dn);
    end
  endtask

  task automatic test_zero_key();
    int cw, dn;
    logic [1:0] bo;
    sel = 2'd1;
    for (int x = 0; x < 256; x++) pmem[x] = 8'h00;
    compute_ks(24'h0, 32);
    push_model(32);
    pulse_start(1, 24'h000000);
    drain_run(6000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 32 || dn != 1) begin
      failed++;
      $display("FAIL zero_key_counts: c_wren=%0d done=%0d, required 32 and 1", cw, dn);
    end
    for (int x = 0; x < 32; x++) pmem[x] = cmem[x];
    for (int x = 0; x < 32; x++) exp_q.push_back({8'(x), 8'h00});
    pulse_start(1, 24'h000000);
    drain_run(6000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 32 || dn != 1) begin
      failed++;
      $display("FAIL reencrypt_counts: c_wren=%0d done=%0d, required 32 and 1", cw, dn);
    end
  endtask

  task automatic test_restart_ignored();
    int cw, dn;
    logic [1:0] bo;
    sel = 2'd0;
    load_plaintext();
    push_ref_vector();
    pulse_start(0, 24'h4B6579);
    repeat (600) @(negedge clk);
    pulse_start(0, 24'h123456);
    secret_key = 24'h4B6579;
    compared++;
    if (busy_v[0] !== 1'b1) begin
      failed++;
      $display("FAIL busy_mid_ksa: busy=%b, required 1", busy_v[0]);
    end
    drain_run(6000, 1'b1, cw, dn, bo);
    compared++;
    if (cw != 9 || dn != 1) begin
      failed++;
      $display("FAIL restart_counts: c_wren=%0d done=%0d, required 9 and 1", cw, dn);
    end
    compared++;
    if (bo !== 2'b10) begin
      failed++;
      $display("FAIL done_cycle_start: busy after DONE/IDLE starts=%b, required 10", bo);
    end
    push_ref_vector();
    drain_run(6000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 9 || dn != 1) begin
      failed++;
      $display("FAIL back_to_back_counts: c_wren=%0d done=%0d, required 9 and 1", cw, dn);
    end
  endtask

  task automatic test_reset_mid_prga();
    int cw = 0;
    int cyc = 0;
    int dn;
    bit wr_bad = 0;
    logic [15:0] e;
    logic [1:0] bo;
    sel = 2'd0;
    load_plaintext();
    push_ref_vector();
    pulse_start(0, 24'h4B6579);
    while (cw < 3 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (c_wren_v[0]) begin
        cw++;
        e = exp_q.pop_front();
        compared++;
        if ({c_addr_v[0], c_wdata_v[0]} !== e) begin
          failed++;
          $display("FAIL pre_reset_write: addr/data=%02h/%02h, required %02h/%02h", c_addr_v[0], c_wdata_v[0], e[15:8], e[7:0]);
        end
      end
    end
    compared++;
    if (cw != 3) begin
      failed++;
      $display("FAIL pre_reset_timeout: writes=%0d, required 3", cw);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    compared++;
    if ({busy_v[0], s_wren_v[0], c_wren_v[0]} !== 3'b000) begin
      failed++;
      $display("FAIL after_reset: busy/s_wren/c_wren=%b%b%b, required 000", busy_v[0], s_wren_v[0], c_wren_v[0]);
    end
    repeat (5) begin
      @(negedge clk);
      if (s_wren_v[0] || c_wren_v[0] || busy_v[0]) wr_bad = 1;
    end
    compared++;
    if (wr_bad) begin
      failed++;
      $display("FAIL post_reset_quiet: activity after abort, required none");
    end
    exp_q.delete();
    push_ref_vector();
    pulse_start(0, 24'h4B6579);
    drain_run(6000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 9 || dn != 1) begin
      failed++;
      $display("FAIL rerun_counts: c_wren=%0d done=%0d, required 9 and 1", cw, dn);
    end
  endtask

  task automatic test_full_length();
    logic [23:0] kk;
    int cw, dn;
    logic [1:0] bo;
    sel = 2'd2;
    kk = 24'($urandom);
    for (int x = 0; x < 256; x++) pmem[x] = 8'($urandom);
    compute_ks(kk, 256);
    push_model(256);
    pulse_start(2, kk);
    drain_run(8000, 1'b0, cw, dn, bo);
    compared++;
    if (cw != 256 || dn != 1) begin
      failed++;
      $display("FAIL full_length_counts: c_wren=%0d done=%0d, required 256 and 1", cw, dn);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_known_vector();
    test_zero_key();
    test_restart_ignored();
    test_reset_mid_prga();
    test_full_length();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/rc4_encryptor.md
RC4_ENCRYPTOR -- requirements
Module: rc4_encryptor

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, giving the number of message bytes processed per run (legal range 1..256).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to begin one encryption run.
REQ-005 SHALL have port secret_key, input, 24 bits: RC4 key; key byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0].
REQ-006 SHALL have port s_addr, output, 8 bits: S-box RAM address.
REQ-007 SHALL have port s_wdata, output, 8 bits: S-box RAM write data.
REQ-008 SHALL have port s_wren, output, 1 bit: S-box RAM write enable.
REQ-009 SHALL have port s_rdata, input, 8 bits: S-box RAM read data.
REQ-010 SHALL have port p_addr, output, 8 bits: plaintext ROM address.
REQ-011 SHALL have port p_rdata, input, 8 bits: plaintext ROM read data.
REQ-012 SHALL have port c_addr, output, 8 bits: ciphertext RAM address.
REQ-013 SHALL have port c_wdata, output, 8 bits: ciphertext RAM write data.
REQ-014 SHALL have port c_wren, output, 1 bit: ciphertext RAM write enable.
REQ-015 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when the last ciphertext byte is written.

Function
REQ-017 All RAM/ROM reads SHALL have one-cycle latency: an address driven in cycle N gives data in cycle N+1; the FSM SHALL insert a wait state before every read is consumed.
REQ-018 start SHALL be accepted only in IDLE; secret_key SHALL be captured in that cycle; start while busy SHALL be ignored.
REQ-019 States SHALL be IDLE, INIT, KSA_RD_I, KSA_WAIT_I, KSA_RD_J, KSA_WAIT_J, KSA_WR_I, KSA_WR_J, PRGA_RD_I, PRGA_WAIT_I, PRGA_RD_J, PRGA_WAIT_J, PRGA_WR_I, PRGA_WR_J, PRGA_RD_F, PRGA_WAIT_F, PRGA_WR_C, DONE.
REQ-020 INIT SHALL write s[k]=k for k=0..255, one write per cycle, 256 cycles.
REQ-021 KSA SHALL, for i=0..255: j = j + s[i] + key[i mod 3] (mod 256, j cleared at KSA entry), then swap s[i] and s[j] (write s[i]<=old s[j], then s[j]<=old s[i]).
REQ-022 When i==j in any swap, the two writes SHALL leave s[i] unchanged.
REQ-023 PRGA SHALL, for k=0..MSG_LEN-1, with i and j cleared at PRGA entry: i=i+1; j=j+s[i]; swap s[i],s[j]; f=s[(s[i]+s[j]) mod 256] using post-swap values; c[k]=f XOR p[k].
REQ-024 p[k] SHALL be fetched via p_addr=k concurrently with the f read, so no extra cycles are needed.
REQ-025 All index arithmetic SHALL be 8-bit modulo 256; the loop counter SHALL be 9 bits so that MSG_LEN=256 terminates.
REQ-026 c_wren SHALL be high exactly one cycle per byte, with c_addr=k and c_wdata=c[k]; exactly MSG_LEN writes SHALL occur per run.
REQ-027 s_wren and c_wren SHALL never be asserted in IDLE or DONE.
REQ-028 DONE SHALL assert done for one cycle and deassert busy, then return to IDLE on the next cycle.
REQ-029 A start arriving in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-030 With reset_n low at a rising edge, the FSM SHALL enter IDLE.
REQ-031 Reset SHALL set busy=0, done=0, s_wren=0, c_wren=0 and all addresses, write data, i, j, k and the captured key to 0.
REQ-032 Reset mid-run SHALL abort the run with no further writes; RAM contents are then undefined and the next start SHALL redo INIT.

Verification
REQ-033 MSG_LEN=9, key 0x4B6579 ("Key"), plaintext "Plaintext" -> c[0..8] = BB F3 16 E8 D9 40 AF 0A D3; one done pulse; exactly 9 c_wren cycles.
REQ-034 Any key, stalled before KSA -> s[k]==k for all k after INIT; INIT takes exactly 256 s_wren cycles.
REQ-035 Plaintext all 0x00, key 0x000000, MSG_LEN=32 -> ciphertext equals the reference RC4 keystream; re-encrypting the ciphertext restores all zeros.
REQ-036 Assert start again at mid-KSA and in the DONE cycle -> both ignored; outputs identical to a single run.
REQ-037 reset_n low for 1 cycle during PRGA -> next cycle busy=0, s_wren=0, c_wren=0; a new start with key 0x4B6579 again produces REQ-033's result.
REQ-038 MSG_LEN=256 -> c_addr runs 0x00..0xFF with no wrap-around write, then done asserts.
